seg7_scan_rx: RTL and testbench

- Receive side of the 7-segment display interface: samples a multiplexed, scanned segment bus (shared segment lines plus per-digit enables) and recovers the hex nibble shown on each digit.
- Used as a loopback checker and monitor behind the seg7 decoder and display scanner, so hex values driven to the display can be read back in-system.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_rx_if.sv | 16 +
 rtl/seg7_pattern_dec.sv | 40 ++++
 rtl/seg7_scan_rx.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_rx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment receive path.
//   - SEG7_HEX_0..SEG7_HEX_F : active-low {g,f,e,d,c,b,a} patterns per hex digit
//   - SEG7_BLANK             : all segments off
//   - rx_state_e             : scan receiver FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG7_HEX_0 = 7'h40;
    localparam logic [6:0] SEG7_HEX_1 = 7'h79;
    localparam logic [6:0] SEG7_HEX_2 = 7'h24;
    localparam logic [6:0] SEG7_HEX_3 = 7'h30;
    localparam logic [6:0] SEG7_HEX_4 = 7'h19;
    localparam logic [6:0] SEG7_HEX_5 = 7'h12;
    localparam logic [6:0] SEG7_HEX_6 = 7'h02;
    localparam logic [6:0] SEG7_HEX_7 = 7'h78;
    localparam logic [6:0] SEG7_HEX_8 = 7'h00;
    localparam logic [6:0] SEG7_HEX_9 = 7'h10;
    localparam logic [6:0] SEG7_HEX_A = 7'h08;
    localparam logic [6:0] SEG7_HEX_B = 7'h03;
    localparam logic [6:0] SEG7_HEX_C = 7'h46;
    localparam logic [6:0] SEG7_HEX_D = 7'h21;
    localparam logic [6:0] SEG7_HEX_E = 7'h06;
    localparam logic [6:0] SEG7_HEX_F = 7'h0E;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/seg7_scan_rx_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_rx_if
// Scanned segment bus as seen at the display pins.
//   seg_in [6:0]            shared segment lines {g..a}, active-low
//   dig_en [NUM_DIGITS-1:0] digit enables, active-high, one-hot when driven
// Modports: master drives the bus (scanner / bench), slave observes it.
// -----------------------------------------------------------------------------
interface seg7_scan_rx_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] dig_en;

    modport master (output seg_in, output dig_en);
    modport slave  (input  seg_in, input  dig_en);
endinterface

// File: rtl/seg7_pattern_dec.sv
// -----------------------------------------------------------------------------
// seg7_pattern_dec
// Combinational inverse of the hex-to-7-segment table.
//   seg_i    [6:0] active-low pattern {g..a}
//   hit_o          pattern is one of the 16 hex glyphs
//   nibble_o [3:0] decoded value (0 when hit_o is low)
// -----------------------------------------------------------------------------
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG7_HEX_0: nibble_o = 4'h0;
            SEG7_HEX_1: nibble_o = 4'h1;
            SEG7_HEX_2: nibble_o = 4'h2;
            SEG7_HEX_3: nibble_o = 4'h3;
            SEG7_HEX_4: nibble_o = 4'h4;
            SEG7_HEX_5: nibble_o = 4'h5;
            SEG7_HEX_6: nibble_o = 4'h6;
            SEG7_HEX_7: nibble_o = 4'h7;
            SEG7_HEX_8: nibble_o = 4'h8;
            SEG7_HEX_9: nibble_o = 4'h9;
            SEG7_HEX_A: nibble_o = 4'hA;
            SEG7_HEX_B: nibble_o = 4'hB;
            SEG7_HEX_C: nibble_o = 4'hC;
            SEG7_HEX_D: nibble_o = 4'hD;
            SEG7_HEX_E: nibble_o = 4'hE;
            SEG7_HEX_F: nibble_o = 4'hF;
            default:    hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// -----------------------------------------------------------------------------
// seg7_scan_rx
// Monitors a scanned 7-segment bus and recovers the hex nibble on each digit.
// Ports:
//   clk, rst_n          system clock (rising), async active-low reset
//   bus_if (slave)      seg_in / dig_en from the display pins (asynchronous)
//   value  [4N-1:0]     recovered nibbles, digit i at [4i+3:4i]
//   valid  [N-1:0]      digit i holds a decoded nibble
//   frame_done          pulse when every digit has been captured since last pulse
//   err                 pulse on undecodable pattern or multi-hot enable capture
//   err_cnt [7:0]       saturating count of err pulses
// Build option: SEG7_RX_BLANK_EN makes 7'h7F a legal blank (no err, valid=0).
//
// state  | meaning
// IDLE   | no digit enabled
// SETTLE | counting consecutive identical samples
// HOLD   | sample captured, waiting for the bus to change
// -----------------------------------------------------------------------------
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg7_scan_rx_if.slave           bus_if,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic                    frame_done,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    // Capture fires on the edge where the STABLE_CYCLES-th identical sample
    // is counted, i.e. while cnt_q still holds one less.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]              seg_meta_q, s_seg_q, prev_seg_q;
    logic [NUM_DIGITS-1:0]   en_meta_q, s_en_q, prev_en_q;
    rx_state_e               state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    capture;
    logic                    change, en_zero, onehot, hit, blank_ok;
    logic [3:0]              nibble;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, mask_q, mask_d;
    logic                    err_q, err_d, fd_q, fd_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= SEG7_BLANK;
            s_seg_q    <= SEG7_BLANK;
            prev_seg_q <= SEG7_BLANK;
            en_meta_q  <= '0;
            s_en_q     <= '0;
            prev_en_q  <= '0;
        end else begin
            seg_meta_q <= bus_if.seg_in;
            s_seg_q    <= seg_meta_q;
            prev_seg_q <= s_seg_q;
            en_meta_q  <= bus_if.dig_en;
            s_en_q     <= en_meta_q;
            prev_en_q  <= s_en_q;
        end
    end

    assign change  = (s_seg_q != prev_seg_q) || (s_en_q != prev_en_q);
    assign en_zero = (s_en_q == '0);
    assign onehot  = $onehot(s_en_q);

    seg7_pattern_dec u_dec (
        .seg_i    (s_seg_q),
        .hit_o    (hit),
        .nibble_o (nibble)
    );

`ifdef SEG7_RX_BLANK_EN
    assign blank_ok = (s_seg_q == SEG7_BLANK);
`else
    assign blank_ok = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!en_zero) state_d = SETTLE;
            SETTLE:  if (change) state_d = en_zero ? IDLE : SETTLE;
                     else if (cnt_q == CNT_LAST) state_d = HOLD;
            HOLD:    if (change) state_d = en_zero ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (stability counter and capture strobe)
    always_comb begin
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE:   cnt_d = en_zero ? 8'd0 : 8'd1;
            SETTLE: begin
                if (change) begin
                    cnt_d = en_zero ? 8'd0 : 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) capture = 1'b1;
                end
            end
            HOLD:    if (change) cnt_d = en_zero ? 8'd0 : 8'd1;
            default: cnt_d = 8'd0;
        endcase
    end

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        fd_d    = 1'b0;
        if (capture) begin
            if (onehot) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_en_q[i]) begin
                        if (hit) value_d[4*i +: 4] = nibble;
                        valid_d[i] = hit;
                        mask_d[i]  = 1'b1;
                    end
                end
                err_d = !hit && !blank_ok;
            end else begin
                err_d = 1'b1;
            end
            if (&mask_d) begin
                fd_d   = 1'b1;
                mask_d = '0;
            end
        end
    end

    assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            valid_q   <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            fd_q      <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            value_q   <= value_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            fd_q      <= fd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign value      = value_q;
    assign valid      = valid_q;
    assign frame_done = fd_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_rx
// Drives the scanned bus as runs of constant {seg, dig_en}. The reference model
// treats any run lasting STABLE_CYCLES sampling edges as one capture that
// becomes visible two edges later, and applies the decode table rules to it.
// -----------------------------------------------------------------------------
module tb_seg7_scan_rx;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_rx_if #(.NUM_DIGITS(ND)) bus ();

    logic [4*ND-1:0] value;
    logic [ND-1:0]   valid;
    logic            frame_done, err;
    logic [7:0]      err_cnt;

    seg7_scan_rx #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_if     (bus),
        .value      (value),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic          v;
        logic [6:0]    s;
        logic [ND-1:0] e;
    } ev_t;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0]      m_val [ND];
    logic [ND-1:0]   m_valid, m_mask;
    logic            m_err, m_fd;
    int              m_errcnt;
    logic [6+ND:0]   run_key;
    logic            run_ok;
    int              run_len;
    ev_t             pipe0, pipe1;

    int n_vec = 0;
    int n_bad = 0;

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (hex_tbl[k] == s) return k;
        return -1;
    endfunction

    function automatic bit is_blank(input logic [6:0] s);
`ifdef SEG7_RX_BLANK_EN
        return s == 7'h7F;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
        m_valid = '0; m_mask = '0; m_err = 1'b0; m_fd = 1'b0; m_errcnt = 0;
        run_ok = 1'b0; run_len = 0; run_key = '0;
        pipe0 = '0; pipe1 = '0;
    endtask

    task automatic model_apply(input ev_t ev);
        int d;
        m_err = 1'b0;
        m_fd  = 1'b0;
        if (!ev.v) return;
        if ($countones(ev.e) == 1) begin
            for (int i = 0; i < ND; i++) begin
                if (ev.e[i]) begin
                    d = decode(ev.s);
                    if (d >= 0) begin
                        m_val[i]   = d[3:0];
                        m_valid[i] = 1'b1;
                    end else begin
                        m_valid[i] = 1'b0;
                        if (!is_blank(ev.s)) m_err = 1'b1;
                    end
                    m_mask[i] = 1'b1;
                end
            end
        end else begin
            m_err = 1'b1;
        end
        if (m_mask == '1) begin
            m_fd   = 1'b1;
            m_mask = '0;
        end
        if (m_err && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] e);
        ev_t nw;
        nw = '0;
        if (run_ok && {s, e} == run_key) begin
            run_len++;
        end else begin
            run_key = {s, e};
            run_len = 1;
            run_ok  = 1'b1;
        end
        if (run_len == SC && e != '0) nw = {1'b1, s, e};
        model_apply(pipe1);
        pipe1 = pipe0;
        pipe0 = nw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [4*ND-1:0] ev;
        for (int i = 0; i < ND; i++) ev[4*i +: 4] = m_val[i];
        chk("value",      32'(value),      32'(ev));
        chk("valid",      32'(valid),      32'(m_valid));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("err",        32'(err),        32'(m_err));
        chk("err_cnt",    32'(err_cnt),    32'(m_errcnt));
    endtask

    task automatic step(input logic [6:0] s, input logic [ND-1:0] e);
        @(negedge clk);
        bus.seg_in = s;
        bus.dig_en = e;
        @(posedge clk);
        model_edge(s, e);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [6:0] s, input logic [ND-1:0] e, input int n);
        for (int k = 0; k < n; k++) step(s, e);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]    rs;
        logic [ND-1:0] re;
        int            r;

        bus.seg_in = 7'h7F;
        bus.dig_en = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle bus after reset
        hold(7'h7F, 4'b0000, 50);

        // Basic capture and hold
        hold(7'h30, 4'b0001, 12);
        chk("basic_nibble", 32'(value[3:0]), 32'h3);

        // Full frame 2, A, d, F
        hold(7'h24, 4'b0001, 10);
        hold(7'h08, 4'b0010, 10);
        hold(7'h21, 4'b0100, 10);
        hold(7'h0E, 4'b1000, 10);
        hold(7'h7F, 4'b0000, 8);
        chk("frame_value", 32'(value), 32'hFDA2);
        chk("frame_valid", 32'(valid), 32'hF);

        // Glitch rejection
        for (int k = 0; k < 4; k++) begin
            hold(7'h40, 4'b0001, 3);
            hold(7'h79, 4'b0001, 3);
        end
        hold(7'h79, 4'b0001, 10);
        chk("glitch_nibble", 32'(value[3:0]), 32'h1);

        // Errors: undecodable, multi-hot, saturation
        hold(7'h55, 4'b0010, 10);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        hold(7'h55, 4'b0011, 10);
        chk("err_cnt_2", 32'(err_cnt), 32'd2);
        for (int k = 0; k < 150; k++) begin
            hold(7'h55, 4'b0010, 5);
            hold(7'h56, 4'b0010, 5);
        end
        chk("err_cnt_sat", 32'(err_cnt), 32'hFF);

        // Blank pattern
        hold(7'h7F, 4'b0100, 10);
        chk("blank_valid2", 32'(valid[2]), 32'd0);

        // Fresh counters, then randomized runs
        do_reset(2);
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 75) rs = hex_tbl[$urandom_range(0, 15)];
            else        rs = 7'($urandom);
            r = $urandom_range(0, 99);
            if (r < 70)      re = ND'(1 << $urandom_range(0, ND - 1));
            else if (r < 85) re = '0;
            else             re = ND'($urandom);
            hold(rs, re, $urandom_range(1, 8));
        end

        // Reset mid-settle and on a pending capture
        hold(7'h30, 4'b0001, 3);
        do_reset(2);
        hold(7'h7F, 4'b0000, 5);
        hold(7'h12, 4'b0010, SC + 1);
        do_reset(2);
        hold(7'h7F, 4'b0000, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
